input_port_buffer: RTL and testbench

Per-port input buffering stage directly downstream of the route-computation block. It accepts flits from the link and takes the 3-bit output-direction code (vc_select) computed combinationally from the same flit. On a head flit it locks that direction for the whole packet and steers every flit up to the tail into one of five per-direction FIFOs (N, S, E, W, L). Each FIFO presents a valid/ready interface to the switch allocator/crossbar.

---
 rtl/input_port_buffer.sv | 148 ++++++++++++++
 tb/tb_input_port_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// input_port_buffer: flit input stage with packet-locked steering into five direction FIFOs.
// Optional drop counter output enabled by INPUT_PORT_BUFFER_DROP_CNT_EN.
module input_port_buffer #(
    parameter int MSB_SLOT = 5,
    parameter int DSIZE    = 1 << MSB_SLOT,
    parameter int DEPTH    = 4,
    parameter int PTRW     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DSIZE-1:0]   in_data,
    output logic               in_ready,
    input  logic [2:0]         vc_select,
    output logic [4:0]         out_valid,
    output logic [5*DSIZE-1:0] out_data,
    input  logic [4:0]         out_ready,
    output logic               err_proto
`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

    state_t     state;
    logic [2:0] route_q;
    logic [2:0] target;
    logic       drop;
    logic       accept;
    logic       push;
    logic [4:0] full;
    logic [7:0] full_x;

    logic is_head, is_body, is_tail, is_bad, vc_ok;

    assign is_head = in_data[1:0] == 2'b11;
    assign is_body = in_data[1:0] == 2'b01;
    assign is_tail = in_data[1:0] == 2'b10;
    assign is_bad  = in_data[1:0] == 2'b00;
    assign vc_ok   = vc_select <= 3'd4;

    // Pick the destination FIFO and decide whether this flit is discarded.
    always_comb begin
        drop   = 1'b0;
        target = route_q;
        unique case (1'b1)
            is_bad: begin
                drop = 1'b1;
                if (state != PKT) target = vc_select;
            end
            is_head: begin
                target = vc_select;
                drop   = !vc_ok;
            end
            default: begin
                drop = state != PKT;
                if (state != PKT) target = vc_select;
            end
        endcase
    end

    assign full_x   = {3'b000, full};
    assign in_ready = !reset && (drop || !full_x[target]);
    assign accept   = in_valid && in_ready;
    assign push     = accept && !drop;

    for (genvar d = 0; d < 5; d++) begin : g_fifo
        logic [DSIZE-1:0] mem [DEPTH];
        logic [PTRW-1:0]  wr_ptr;
        logic [PTRW-1:0]  rd_ptr;
        logic [PTRW:0]    count;
        logic             wr;
        logic             rd;

        assign wr           = push && (target == 3'(d));
        assign rd           = out_valid[d] && out_ready[d];
        assign out_valid[d] = count != '0;
        assign full[d]      = count == CNT_FULL;
        assign out_data[d*DSIZE +: DSIZE] = mem[rd_ptr];

        // Storage needs no reset; contents are ignored while empty.
        always_ff @(posedge clk) begin
            if (wr) mem[wr_ptr] <= in_data;
        end

        // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (rd) rd_ptr <= rd_ptr + 1'b1;
                if (wr && !rd) count <= count + 1'b1;
                else if (rd && !wr) count <= count - 1'b1;
            end
        end
    end

    // Packet FSM: lock route on head, release on tail, flag protocol errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            route_q   <= 3'b000;
            err_proto <= 1'b0;
        end else if (accept) begin
            unique case (1'b1)
                is_bad: err_proto <= 1'b1;
                is_head: begin
                    if (state == PKT) err_proto <= 1'b1;
                    if (vc_ok) begin
                        route_q <= vc_select;
                        state   <= PKT;
                    end else begin
                        state <= DROP;
                    end
                end
                is_body: begin
                    if (state == IDLE) err_proto <= 1'b1;
                end
                is_tail: begin
                    if (state == IDLE) err_proto <= 1'b1;
                    else state <= IDLE;
                end
                default: ;
            endcase
        end
    end

`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
    // Saturating count of accepted flits that were discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else if (accept && drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomized scoreboard bench for input_port_buffer.
// Reference model tracks packet mode and per-direction expected queues.
module tb_input_port_buffer;

    localparam int DSIZE = 32;
    localparam int DEPTH = 4;

    logic             clk = 0;
    logic             reset;
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_ready;
    logic [2:0]       vc_select;
    logic [4:0]       out_valid;
    logic [5*DSIZE-1:0] out_data;
    logic [4:0]       out_ready;
    logic             err_proto;
`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    input_port_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .vc_select (vc_select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err_proto (err_proto)
`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DSIZE-1:0] sbq [5][$];

    // Model: mode 0 = waiting for head, 1 = in packet to m_dir, 2 = discarding.
    int m_mode = 0;
    int m_dir  = 0;
    bit m_err  = 0;
    int m_drops = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 5; d++) sbq[d].delete();
        m_mode  = 0;
        m_dir   = 0;
        m_err   = 0;
        m_drops = 0;
    endtask

    // Monitor: compare presented FIFO heads against the scoreboard and pop.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 5; d++) begin
                check($sformatf("out_valid[%0d]", d), out_valid[d], sbq[d].size() != 0);
                if (out_valid[d] && out_ready[d] && sbq[d].size() != 0) begin
                    check($sformatf("out_data[%0d]", d),
                          out_data[d*DSIZE +: DSIZE], sbq[d][0]);
                    void'(sbq[d].pop_front());
                end
            end
        end
    end

    // Driver and reference model.
    initial begin
        bit       acc;
        bit       exp_drop;
        int       tgt;
        int       rdy_pct;
        int       r;
        logic [1:0] t;

        reset     = 1;
        in_valid  = 0;
        in_data   = '0;
        vc_select = 3'b000;
        out_ready = 5'b0;
        model_clear();
        @(negedge clk);
        in_valid = 1;
        in_data  = 32'h0000_0003;
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset err_proto", err_proto, 0);
`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
        check("reset drop_cnt", drop_cnt, 0);
`endif
        @(negedge clk);
        reset    = 0;
        in_valid = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500 || cyc == 2700) begin
                reset    = 1;
                in_valid = 0;
                #1;
                check("async out_valid", out_valid, 0);
                check("reset in_ready", in_ready, 0);
                check("reset err_proto", err_proto, 0);
                model_clear();
                @(posedge clk);
                @(negedge clk);
                reset = 0;
            end

            rdy_pct = (cyc >= 500 && cyc < 900) ? 10 : 60;
            if (cyc >= 2000 && cyc < 2200) rdy_pct = 0;
            for (int d = 0; d < 5; d++)
                out_ready[d] = $urandom_range(0, 99) < rdy_pct;

            in_valid = $urandom_range(0, 99) < 75;
            in_data  = $urandom;
            r = $urandom_range(0, 99);
            if (r < 25) t = 2'b11;
            else if (r < 65) t = 2'b01;
            else if (r < 92) t = 2'b10;
            else t = 2'b00;
            in_data[1:0] = t;
            if ($urandom_range(0, 99) < 85) vc_select = 3'($urandom_range(0, 4));
            else vc_select = 3'($urandom_range(5, 7));

            exp_drop = 0;
            tgt = 0;
            if (t == 2'b11) begin
                exp_drop = vc_select > 3'd4;
                tgt = int'(vc_select);
            end else if (t == 2'b00) begin
                exp_drop = 1;
            end else begin
                exp_drop = m_mode != 1;
                tgt = m_dir;
            end

            #1;
            check("in_ready",
                  in_ready, exp_drop ? 1 : (sbq[tgt].size() < DEPTH));
            check("err_proto", err_proto, m_err);
`ifdef INPUT_PORT_BUFFER_DROP_CNT_EN
            check("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
`endif
            acc = in_valid && in_ready;

            @(posedge clk);
            if (acc) begin
                if (exp_drop) m_drops++;
                if (t == 2'b00) begin
                    m_err = 1;
                end else if (t == 2'b11) begin
                    if (m_mode == 1) m_err = 1;
                    if (!exp_drop) begin
                        sbq[tgt].push_back(in_data);
                        m_mode = 1;
                        m_dir  = tgt;
                    end else begin
                        m_mode = 2;
                    end
                end else begin
                    if (m_mode == 0) m_err = 1;
                    else if (m_mode == 1) sbq[m_dir].push_back(in_data);
                    if (t == 2'b10 && m_mode != 0) m_mode = 0;
                end
            end
        end

        @(negedge clk);
        in_valid = 0;
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
